// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, core load port and status outputs of the UART receiver
interface uart_rx_if;
  logic        rxd;
  logic        re;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        rd_hit;
  logic        rx_avail;
  logic        rx_err;
  modport master (output rxd, re, addr, input rdata, rd_hit, rx_avail, rx_err);
  modport slave  (input rxd, re, addr, output rdata, rd_hit, rx_avail, rx_err);
endinterface

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 8N1 UART receiver feeding a FIFO, read through data/status load addresses
module uart_rx_mmio #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_AW      = 4,
  parameter logic [31:0] DATA_ADDR    = 32'h10,
  parameter logic [31:0] STAT_ADDR    = 32'h14
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic                 fe_q, fe_d, ov_q, ov_d, rd_hit_q, rd_hit_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rxd_s, push, fe_evt, data_rd, stat_rd, empty, full, pop, accept;
  assign rxd_s    = sync_q[1];
  assign data_rd  = bus.re && bus.addr == DATA_ADDR;
  assign stat_rd  = bus.re && bus.addr == STAT_ADDR;
  assign empty    = count_q == '0;
  assign full     = count_q == DEPTH;
  assign pop      = data_rd && !empty;
  assign accept   = push && (!full || pop);
  assign wp_d     = accept ? wp_q + 1'b1 : wp_q;
  assign rp_d     = pop ? rp_q + 1'b1 : rp_q;
  assign count_d  = (accept && !pop) ? count_q + 1'b1 : (pop && !accept) ? count_q - 1'b1 : count_q;
  assign fe_d     = (fe_q && !stat_rd) || fe_evt;
  assign ov_d     = (ov_q && !stat_rd) || (push && !accept);
  assign rd_hit_d = data_rd || stat_rd;
  assign rdata_d  = stat_rd ? {28'b0, fe_q, ov_q, full, !empty} :
                    !data_rd ? rdata_q :
                    empty ? '0 : {23'b0, 1'b1, mem_q[rp_q]};
  assign bus.rdata    = rdata_q;
  assign bus.rd_hit   = rd_hit_q;
  assign bus.rx_avail = !empty;
  assign bus.rx_err   = fe_q || ov_q;
  // Two-stage synchroniser; reset to the idle-high line level
  always_ff @(posedge clk) sync_q <= reset ? 2'b11 : {sync_q[0], bus.rxd};
  // Receiver, FIFO bookkeeping and registered read port
  always_ff @(posedge clk)
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
      rd_hit_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
      rd_hit_q <= rd_hit_d;
      rdata_q  <= rdata_d;
    end
  // FIFO storage; entries left behind by a reset are unreachable through the cleared pointers
  always_ff @(posedge clk) if (accept) mem_q[wp_q] <= shift_q;
  // Frame FSM: centre on the start bit, then sample each bit one bit period apart
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == LAST) begin
        cnt_d   = '0;
        shift_d = {rxd_s, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == LAST) begin
        cnt_d   = '0;
        push    = rxd_s;
        fe_evt  = !rxd_s;
        state_d = rxd_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
